// File: rtl/bpu.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit direction counters, trained by execute.
// Latency: one cycle from q_pc (q_en=1) to p_hit/p_taken/p_target; updates commit at the edge they are presented.
// Backpressure: none; q_en=0 freezes the prediction outputs, updates are always accepted (dropped while sweeping).
module bpu #(
    parameter  int IDX_W   = 6,
    localparam int TAG_W   = 30 - IDX_W,
    localparam int ENTRIES = 2 ** IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        q_en,
    input  logic [31:0] q_pc,
    output logic        p_hit,
    output logic        p_taken,
    output logic [31:0] p_target,
    output logic        ready,
    input  logic        u_valid,
    input  logic [31:0] u_pc,
    input  logic [1:0]  u_kind,
    input  logic        u_taken,
    input  logic [31:0] u_target
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [1:0]       KIND_COND = 2'd0;
    localparam logic [1:0]       KIND_RSVD = 2'd3;
    localparam logic [IDX_W-1:0] LAST_IDX  = '1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;

    logic               valid_q [ENTRIES];
    logic               valid_d [ENTRIES];
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [TAG_W-1:0]   tag_d   [ENTRIES];
    logic [29:0]        tgt_q   [ENTRIES];
    logic [29:0]        tgt_d   [ENTRIES];
    logic [1:0]         cnt_q   [ENTRIES];
    logic [1:0]         cnt_d   [ENTRIES];

    logic               p_hit_q, p_hit_d;
    logic               p_taken_q, p_taken_d;
    logic [31:0]        p_target_q, p_target_d;

    logic [IDX_W-1:0]   q_idx, u_idx;
    logic [TAG_W-1:0]   q_tag, u_tag;
    logic               q_hit, u_hit;

    // Byte-offset bits of the PCs/targets carry no information for word-aligned instructions.
    logic unused_ok;
    assign unused_ok = ^{q_pc[1:0], u_pc[1:0], u_target[1:0]};

    assign q_idx = q_pc[IDX_W+1:2];
    assign q_tag = q_pc[31:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[31:IDX_W+2];
    assign q_hit = valid_q[q_idx] && (tag_q[q_idx] == q_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // FSM state register and sweep counter; reset restarts the clearing sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // FSM next state: leave INIT once the last entry has been cleared.
    always_comb begin
        state_d = state_q;
        sweep_d = '0;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    // FSM outputs.
    always_comb begin
        ready = (state_q == ST_RUN);
    end

    // Table next state: sweep clears in INIT, training from execute in RUN.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            valid_d[sweep_q] = 1'b0;
        end else if (u_valid && (u_kind != KIND_RSVD)) begin
            if (u_hit) begin
                if (u_kind == KIND_COND) begin
                    if (u_taken) begin
                        cnt_d[u_idx] = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
                        tgt_d[u_idx] = u_target[31:2];
                    end else begin
                        cnt_d[u_idx] = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
                    end
                end else begin
                    cnt_d[u_idx] = 2'b11;
                    tgt_d[u_idx] = u_target[31:2];
                end
            end else if (u_taken) begin
                // Only taken transfers earn a slot; the previous occupant is evicted.
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = u_target[31:2];
                cnt_d[u_idx]   = (u_kind == KIND_COND) ? 2'b10 : 2'b11;
            end
        end
    end

    // Table storage; contents are made consistent by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        tgt_q   <= tgt_d;
        cnt_q   <= cnt_d;
    end

    // Prediction next state: reads the pre-update table, holds while fetch is stalled.
    always_comb begin
        p_hit_d    = p_hit_q;
        p_taken_d  = p_taken_q;
        p_target_d = p_target_q;
        if (q_en) begin
            if ((state_q == ST_RUN) && q_hit) begin
                p_hit_d    = 1'b1;
                p_taken_d  = cnt_q[q_idx][1];
                p_target_d = {tgt_q[q_idx], 2'b00};
            end else begin
                p_hit_d    = 1'b0;
                p_taken_d  = 1'b0;
                p_target_d = '0;
            end
        end
    end

    // Prediction output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_hit_q    <= 1'b0;
            p_taken_q  <= 1'b0;
            p_target_q <= '0;
        end else begin
            p_hit_q    <= p_hit_d;
            p_taken_q  <= p_taken_d;
            p_target_q <= p_target_d;
        end
    end

    assign p_hit    = p_hit_q;
    assign p_taken  = p_taken_q;
    assign p_target = p_target_q;

endmodule

// File: tb/tb_bpu.sv
// Bench for bpu: lookups push {hit,taken,target} expectations, a monitor pops them one cycle later.
module tb_bpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_en;
    logic [31:0] q_pc;
    logic        p_hit;
    logic        p_taken;
    logic [31:0] p_target;
    logic        ready;
    logic        u_valid;
    logic [31:0] u_pc;
    logic [1:0]  u_kind;
    logic        u_taken;
    logic [31:0] u_target;

    int n_cmp = 0;
    int n_bad = 0;

    logic [33:0] sb_q [$];

    localparam logic [33:0] MISS = 34'd0;

    bpu #(.IDX_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_en     (q_en),
        .q_pc     (q_pc),
        .p_hit    (p_hit),
        .p_taken  (p_taken),
        .p_target (p_target),
        .ready    (ready),
        .u_valid  (u_valid),
        .u_pc     (u_pc),
        .u_kind   (u_kind),
        .u_taken  (u_taken),
        .u_target (u_target)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: each enabled lookup edge retires one expectation.
    always @(posedge clk) begin
        logic [33:0] e;
        if (q_en && !rst) begin
            #1;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: lookup response with no expectation, got hit=%0b taken=%0b target=%h",
                         p_hit, p_taken, p_target);
            end else begin
                e = sb_q.pop_front();
                if ({p_hit, p_taken, p_target} !== e) begin
                    n_bad++;
                    $display("FAIL lookup @%0t: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                             $time, p_hit, p_taken, p_target, e[33], e[32], e[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [33:0] exp_v);
        q_en = 1'b1;
        q_pc = pc;
        sb_q.push_back(exp_v);
        cyc();
        q_en = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [1:0] kind, input logic tk, input logic [31:0] tgt);
        u_valid  = 1'b1;
        u_pc     = pc;
        u_kind   = kind;
        u_taken  = tk;
        u_target = tgt;
        cyc();
        u_valid = 1'b0;
    endtask

    function automatic logic [33:0] hit(input logic tk, input logic [31:0] tgt);
        return {1'b1, tk, tgt};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if ({p_hit, p_taken, p_target, ready} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got hit=%0b taken=%0b target=%h ready=%0b, want all 0",
                     p_hit, p_taken, p_target, ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (ready !== 1'b0) begin
                n_bad++;
                $display("FAIL sweep_ready cycle %0d: got %0b want 0", i, ready);
            end
            // Update during the sweep must be dropped; the last INIT lookup must miss.
            u_valid  = (i == 10);
            u_pc     = 32'h1c000010;
            u_kind   = 2'd1;
            u_taken  = 1'b1;
            u_target = 32'h1c000100;
            if (i == 63) begin
                q_en = 1'b1;
                q_pc = 32'h1c000010;
                sb_q.push_back(MISS);
            end
            cyc();
            u_valid = 1'b0;
            q_en    = 1'b0;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_done: ready got %0b want 1", ready);
        end
        lookup(32'h1c000010, MISS);
    endtask

    task automatic test_alloc();
        update(32'h1c000020, 2'd0, 1'b1, 32'h1c000080);
        lookup(32'h1c000020, hit(1'b1, 32'h1c000080));
    endtask

    task automatic test_counter();
        repeat (3) update(32'h1c000020, 2'd0, 1'b1, 32'h1c000080);
        lookup(32'h1c000020, hit(1'b1, 32'h1c000080));
        update(32'h1c000020, 2'd0, 1'b0, 32'h1c0000f0);
        lookup(32'h1c000020, hit(1'b1, 32'h1c000080));
        update(32'h1c000020, 2'd0, 1'b0, 32'h1c0000f0);
        lookup(32'h1c000020, hit(1'b0, 32'h1c000080));
        repeat (2) update(32'h1c000020, 2'd0, 1'b0, 32'h1c0000f0);
        lookup(32'h1c000020, hit(1'b0, 32'h1c000080));
        update(32'h1c000020, 2'd0, 1'b1, 32'h1c000090);
        lookup(32'h1c000020, hit(1'b0, 32'h1c000090));
        update(32'h1c000020, 2'd0, 1'b1, 32'h1c000090);
        lookup(32'h1c000020, hit(1'b1, 32'h1c000090));
    endtask

    task automatic test_alias();
        update(32'h1c000120, 2'd1, 1'b1, 32'h1c000400);
        lookup(32'h1c000020, MISS);
        lookup(32'h1c000120, hit(1'b1, 32'h1c000400));
    endtask

    task automatic test_same_cycle();
        u_valid  = 1'b1;
        u_pc     = 32'h1c000240;
        u_kind   = 2'd1;
        u_taken  = 1'b1;
        u_target = 32'h1c000800;
        q_en     = 1'b1;
        q_pc     = 32'h1c000240;
        sb_q.push_back(MISS);
        cyc();
        u_valid = 1'b0;
        q_en    = 1'b0;
        lookup(32'h1c000240, hit(1'b1, 32'h1c000800));
        update(32'h1c000300, 2'd0, 1'b0, 32'h1c000a00);
        lookup(32'h1c000300, MISS);
        update(32'h1c000340, 2'd3, 1'b1, 32'h1c000b00);
        lookup(32'h1c000340, MISS);
        update(32'h1c000120, 2'd2, 1'b1, 32'h1c000500);
        lookup(32'h1c000120, hit(1'b1, 32'h1c000500));
    endtask

    task automatic test_stall();
        logic [31:0] pcs [4];
        pcs[0] = 32'h1c000240;
        pcs[1] = 32'h1c000300;
        pcs[2] = 32'h1c000020;
        pcs[3] = 32'h00000000;
        lookup(32'h1c000120, hit(1'b1, 32'h1c000500));
        for (int i = 0; i < 4; i++) begin
            q_en    = 1'b0;
            q_pc    = pcs[i];
            u_valid = (i == 0);
            u_pc    = 32'h1c000120;
            u_kind  = 2'd1;
            u_taken = 1'b1;
            u_target = 32'h1c000600;
            cyc();
            u_valid = 1'b0;
            n_cmp++;
            if ({p_hit, p_taken, p_target} !== hit(1'b1, 32'h1c000500)) begin
                n_bad++;
                $display("FAIL stall_hold cycle %0d: got hit=%0b taken=%0b target=%h, want 1 1 1c000500",
                         i, p_hit, p_taken, p_target);
            end
        end
        lookup(32'h1c000120, hit(1'b1, 32'h1c000600));
    endtask

    task automatic test_mid_reset();
        lookup(32'h1c000240, hit(1'b1, 32'h1c000800));
        rst = 1'b1;
        cyc();
        n_cmp++;
        if ({p_hit, p_taken, p_target, ready} !== 35'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got hit=%0b taken=%0b target=%h ready=%0b, want all 0",
                     p_hit, p_taken, p_target, ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (ready !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_sweep cycle %0d: ready got %0b want 0", i, ready);
            end
            cyc();
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_done: ready got %0b want 1", ready);
        end
        lookup(32'h1c000120, MISS);
        lookup(32'h1c000240, MISS);
        lookup(32'h1c000020, MISS);
    endtask

    initial begin
        rst      = 1'b1;
        q_en     = 1'b0;
        q_pc     = '0;
        u_valid  = 1'b0;
        u_pc     = '0;
        u_kind   = '0;
        u_taken  = 1'b0;
        u_target = '0;
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_same_cycle();
        test_stall();
        test_mid_reset();
        repeat (2) cyc();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d expectations never retired, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
